main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Backing-memory responder on the far side of the cache miss/fill path.
- Accepts word read requests from the cache data controller (miss fills) and word write requests (write-through), each with a fixed multi-cycle latency.
- Returns the read word on word_from_mem and signals completion of every operation with a one-cycle mem_ready pulse.
- Contains the word-addressed storage array and the request FSM.

Parameters:
- ADDR_WIDTH, 10, word-address width; array depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 4, cycles from request acceptance to mem_ready for a read; legal range 1..15.
- WRITE_LATENCY, 2, cycles from request acceptance to mem_ready for a write; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read request; level, held by the requester until mem_ready.
- mem_write  input  1  write request; level, held by the requester until mem_ready.
- mem_addr  input  ADDR_WIDTH  word address; sampled at acceptance.
- mem_wdata  input  DATA_WIDTH  write data; sampled at acceptance.
- word_from_mem  output  DATA_WIDTH  read data; valid in the mem_ready cycle of a read and held until the next read completes.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - word_from_mem = 0, mem_ready = 0, mem_busy = 0.
  - state = IDLE, latency counter = 0.
  - Array contents are not reset.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - If mem_write is 1: latch addr/wdata, counter = WRITE_LATENCY-1, go to WR_WAIT.
  - Else if mem_read is 1: latch addr, counter = READ_LATENCY-1, go to RD_WAIT.
  - Write has priority when both are high. The read stays pending because it is a level request, and is accepted after DONE.
- RD_WAIT: decrement the counter each cycle. When the counter is 0:
  - word_from_mem <= array[latched addr].
  - Assert mem_ready for that one cycle.
  - Go to DONE.
- WR_WAIT: decrement the counter each cycle. When the counter is 0:
  - array[latched addr] <= latched wdata.
  - Assert mem_ready for that one cycle.
  - Go to DONE.
- DONE: one cycle, with mem_ready = 0 and requests ignored; this gives the requester a cycle to drop its level request. Then go to IDLE.
- Latency:
  - Request high in cycle N (IDLE) -> mem_ready in cycle N+READ_LATENCY or N+WRITE_LATENCY.
  - Next acceptance no earlier than N+latency+2.
- mem_ready is never high for more than one consecutive cycle.
- word_from_mem changes only in a read-completion cycle or on reset.
- Address and data changes after acceptance have no effect; only the latched values are used.
- Read-after-write to the same address returns the new data, because the write commits in its mem_ready cycle and the read is accepted at least 2 cycles later.
- Address wrap: the address is exactly ADDR_WIDTH bits, so there is no out-of-range access.
- Reset mid-operation: the operation is aborted and there is no mem_ready. An in-flight write is NOT committed (the array is unchanged). word_from_mem = 0.
- Requests asserted during RD_WAIT, WR_WAIT or DONE are not accepted until IDLE.
- Parameter outside the range 1..15: elaboration error via a generate-time check.

Test Plan:
- Reset then read:
  - Stimulus: preload array[0x005]=0xDEADBEEF; mem_read=1, mem_addr=0x005 at cycle 10.
  - Required: mem_ready high only at cycle 14; word_from_mem=0xDEADBEEF from cycle 14 on; mem_busy high during cycles 11-15.
- Write then read same address:
  - Stimulus: write 0x12345678 to 0x3FF at cycle 5; drop the request after mem_ready (cycle 7); read 0x3FF.
  - Required: read returns 0x12345678; the write's mem_ready comes exactly 2 cycles after acceptance.
- Simultaneous request:
  - Stimulus: mem_read=1 and mem_write=1 to 0x010 (wdata 0xA5A5A5A5), both held.
  - Required: write completes first (mem_ready at +2); the read is accepted after DONE and returns 0xA5A5A5A5.
- Held request:
  - Stimulus: mem_read stays high for 3 cycles past mem_ready.
  - Required: mem_ready pulses exactly once per accepted request; a second read starts only from IDLE, with its pulse READ_LATENCY cycles after re-acceptance.
- Reset mid-write:
  - Stimulus: array[0x020]=0x0; write 0xFFFFFFFF to 0x020; assert rst 1 cycle after acceptance.
  - Required: no mem_ready; array[0x020] still 0x0; all outputs 0.
- Address change during wait:
  - Stimulus: accept a read of 0x001 (contents 0x11), then drive mem_addr=0x002 (contents 0x22).
  - Required: word_from_mem=0x11.

Source files
------------

// File: rtl/main_mem_responder.sv
// Word-addressed backing memory with fixed read/write latency and a one-cycle
// completion pulse; serves cache miss fills and write-through stores.
module main_mem_responder #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] word_from_mem,
  output logic                  mem_ready,
  output logic                  mem_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
    $error("main_mem_responder: READ_LATENCY must be in 1..15");
  end
  if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_write_latency
    $error("main_mem_responder: WRITE_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept_wr_c;
  logic                    accept_rd_c;
  logic                    wr_en_c;
  logic                    rd_fire_c;
  logic [ADDR_WIDTH-1:0]   wr_addr_c;
  logic [DATA_WIDTH-1:0]   wr_data_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;

  // Completion fires one edge early so mem_ready lands in the last wait cycle;
  // a latency of 1 therefore completes on the acceptance edge itself.
  always_comb begin
    accept_wr_c = (state == IDLE) && mem_write;
    accept_rd_c = (state == IDLE) && !mem_write && mem_read;
    wr_en_c     = (accept_wr_c && (WRITE_LATENCY == 1)) ||
                  ((state == WR_WAIT) && (cnt == CNT_W'(1)));
    rd_fire_c   = (accept_rd_c && (READ_LATENCY == 1)) ||
                  ((state == RD_WAIT) && (cnt == CNT_W'(1)));
    wr_addr_c   = accept_wr_c ? mem_addr  : addr_q;
    wr_data_c   = accept_wr_c ? mem_wdata : wdata_q;
    rd_addr_c   = accept_rd_c ? mem_addr  : addr_q;
  end

  // Storage array; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      word_from_mem <= '0;
      mem_ready     <= 1'b0;
      mem_busy      <= 1'b0;
    end else begin
      mem_ready <= rd_fire_c || wr_en_c;
      if (rd_fire_c) begin
        word_from_mem <= mem[rd_addr_c];
      end
      case (state)
        IDLE: begin
          if (accept_wr_c) begin
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            cnt      <= CNT_W'(WRITE_LATENCY - 1);
            state    <= WR_WAIT;
            mem_busy <= 1'b1;
          end else if (accept_rd_c) begin
            addr_q   <= mem_addr;
            cnt      <= CNT_W'(READ_LATENCY - 1);
            state    <= RD_WAIT;
            mem_busy <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: latency, priority, held requests,
// reset abort and address latching with hand-computed expectations.
module tb_main_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] word_from_mem;
  logic        mem_ready;
  logic        mem_busy;

  int checks   = 0;
  int failures = 0;

  main_mem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .word_from_mem (word_from_mem),
    .mem_ready     (mem_ready),
    .mem_busy      (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until mem_ready is seen; bounded so a dead DUT still terminates.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_ready && n < 40);
  endtask

  // One complete transaction from IDLE: request, completion, drop, DONE, back to IDLE.
  task automatic op(input logic wr, input logic [9:0] a, input logic [31:0] d,
                    input int lat, input string tag);
    int n;
    mem_write = wr;
    mem_read  = !wr;
    mem_addr  = a;
    mem_wdata = d;
    wait_ready(n);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_ready"}, {31'd0, mem_busy}, 32'd1);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    step();
    check({tag, "_done_ready"}, {31'd0, mem_ready}, 32'd0);
    check({tag, "_done_busy"}, {31'd0, mem_busy}, 32'd1);
    step();
    check({tag, "_idle_busy"}, {31'd0, mem_busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (3) step();
    check("rst_word", word_from_mem, 32'd0);
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    rst = 1'b0;
    step();

    // Preload then read with 4-cycle latency
    op(1'b1, 10'h005, 32'hDEADBEEF, 2, "pre_wr5");
    op(1'b0, 10'h005, 32'h0, 4, "rd5");
    check("rd5_data", word_from_mem, 32'hDEADBEEF);
    step();
    check("rd5_hold", word_from_mem, 32'hDEADBEEF);

    // Write then read top address
    op(1'b1, 10'h3FF, 32'h12345678, 2, "wr3ff");
    check("wr3ff_word_unchanged", word_from_mem, 32'hDEADBEEF);
    op(1'b0, 10'h3FF, 32'h0, 4, "rd3ff");
    check("rd3ff_data", word_from_mem, 32'h12345678);

    // Simultaneous read and write: write first, read picked up after DONE
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 10'h010;
    mem_wdata = 32'hA5A5A5A5;
    wait_ready(n);
    check("sim_wr_latency", 32'(n), 32'd2);
    check("sim_wr_word_unchanged", word_from_mem, 32'h12345678);
    mem_write = 1'b0;
    wait_ready(n);
    check("sim_rd_gap", 32'(n), 32'd6);
    check("sim_rd_data", word_from_mem, 32'hA5A5A5A5);
    mem_read = 1'b0;
    step();
    check("sim_done_ready", {31'd0, mem_ready}, 32'd0);
    step();

    // Held read: re-accepted only from IDLE, one pulse per acceptance
    mem_read = 1'b1;
    mem_addr = 10'h005;
    wait_ready(n);
    check("held_first_latency", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("held_gap_ready%0d", i), {31'd0, mem_ready}, 32'd0);
    end
    mem_read = 1'b0;
    wait_ready(n);
    check("held_second_gap", 32'(n), 32'd3);
    check("held_second_data", word_from_mem, 32'hDEADBEEF);
    step();
    check("held_single_pulse", {31'd0, mem_ready}, 32'd0);
    step();

    // Reset during a write: aborted, not committed
    op(1'b1, 10'h020, 32'h0, 2, "pre_wr20");
    op(1'b0, 10'h3FF, 32'h0, 4, "rd3ff_again");
    mem_write = 1'b1;
    mem_addr  = 10'h020;
    mem_wdata = 32'hFFFFFFFF;
    step();
    check("abort_busy_before", {31'd0, mem_busy}, 32'd1);
    rst       = 1'b1;
    mem_write = 1'b0;
    step();
    check("abort_ready", {31'd0, mem_ready}, 32'd0);
    check("abort_busy", {31'd0, mem_busy}, 32'd0);
    check("abort_word", word_from_mem, 32'd0);
    rst = 1'b0;
    step();
    check("abort_ready_after", {31'd0, mem_ready}, 32'd0);
    op(1'b0, 10'h020, 32'h0, 4, "rd20");
    check("abort_not_committed", word_from_mem, 32'd0);

    // Address change after acceptance has no effect
    op(1'b1, 10'h001, 32'h11, 2, "pre_wr1");
    op(1'b1, 10'h002, 32'h22, 2, "pre_wr2");
    mem_read = 1'b1;
    mem_addr = 10'h001;
    step();
    mem_addr = 10'h002;
    wait_ready(n);
    check("addr_latch_latency", 32'(n), 32'd3);
    check("addr_latch_data", word_from_mem, 32'h11);
    mem_read = 1'b0;
    repeat (2) step();
    op(1'b0, 10'h002, 32'h0, 4, "rd2");
    check("rd2_data", word_from_mem, 32'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
